// File: rtl/decoder_bus_arbiter_if.sv
// Bus bundle between the four requesters and the chip-select arbiter.
// The master side drives En/Req; the slave side (arbiter) drives grants and decoder selects.
interface decoder_bus_arbiter_if;
  logic       En;
  logic [3:0] Req;
  logic [3:0] Gnt;
  logic       Cs;
  logic       A1;
  logic       A0;
  logic       Busy;
  logic       TimeoutErr;

  modport master (
    output En, Req,
    input  Gnt, Cs, A1, A0, Busy, TimeoutErr
  );

  modport slave (
    input  En, Req,
    output Gnt, Cs, A1, A0, Busy, TimeoutErr
  );
endinterface

// File: rtl/decoder_bus_arbiter.sv
// Round-robin owner selection for a shared peripheral bus behind a 2-4 chip-select decoder.
// state | meaning
// IDLE  | no owner; decoder disabled, address parked at 0
// GRANT | one owner selected; hold counter running toward forced release
// TURN  | single dead cycle after a release; arbitrates for the next owner
module decoder_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic Clk,
  input  logic Rst,
  decoder_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       addr_q, addr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             cs_q, cs_d;
  logic             busy_q, busy_d;
  logic             terr_q, terr_d;

  logic             found;
  logic [1:0]       win;
  logic [1:0]       cand;

  // First requester at or after the round-robin pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && bus.Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE, TURN: begin
        if (bus.En && found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          cs_d    = 1'b0;
          addr_d  = win;
          busy_d  = 1'b1;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          cs_d    = 1'b1;
          addr_d  = 2'b00;
          busy_d  = 1'b0;
          hold_d  = '0;
        end
      end
      GRANT: begin
        hold_d = hold_q + 1'b1;
        // A voluntary drop wins over a coincident timeout, so TimeoutErr follows Req.
        if (!bus.Req[addr_q] || hold_q == HOLD_LAST) begin
          state_d = TURN;
          terr_d  = bus.Req[addr_q];
          gnt_d   = 4'b0000;
          cs_d    = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = addr_q + 2'd1;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'b00;
      addr_q  <= 2'b00;
      hold_q  <= '0;
      gnt_q   <= 4'b0000;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.Gnt        = gnt_q;
  assign bus.Cs         = cs_q;
  assign bus.A1         = addr_q[1];
  assign bus.A0         = addr_q[0];
  assign bus.Busy       = busy_q;
  assign bus.TimeoutErr = terr_q;

endmodule

// File: tb/tb_decoder_bus_arbiter.sv
// Bench for decoder_bus_arbiter: directed scenarios plus a long random run,
// all checked against an owner/pointer model of the round-robin rules.
module tb_decoder_bus_arbiter;
  localparam int MAX_HOLD     = 16;
  localparam int STARVE_LIMIT = 4 * (MAX_HOLD + 1);

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  decoder_bus_arbiter_if bus ();

  decoder_bus_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: current owner (-1 = none), grant cycles served, rotation pointer, timeout pulse.
  int m_owner = -1;
  int m_hold  = 0;
  int m_ptr   = 0;
  bit m_terr  = 1'b0;
  int wait_cyc [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_step(bit r, bit e, logic [3:0] q);
    if (r) begin
      m_owner = -1;
      m_hold  = 0;
      m_ptr   = 0;
      m_terr  = 1'b0;
      return;
    end
    m_terr = 1'b0;
    if (m_owner >= 0) begin
      m_hold++;
      if (!q[m_owner] || m_hold == MAX_HOLD) begin
        m_terr  = q[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end else if (e && q != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (q[(m_ptr + i) % 4]) begin
          m_owner = (m_ptr + i) % 4;
          m_hold  = 0;
          break;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("gnt", bus.Gnt, eg);
    chk("cs", bus.Cs, (m_owner < 0));
    chk("busy", bus.Busy, (m_owner >= 0));
    chk("terr", bus.TimeoutErr, m_terr);
    if (!bus.Cs) chk("addr", {bus.A1, bus.A0}, m_owner);
    chk("gnt_onehot", ($countones(bus.Gnt) <= 1), 1);
    chk("cs_vs_gnt", bus.Cs, ~|bus.Gnt);
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] q, input bit starve_chk);
    Rst     = r;
    bus.En  = e;
    bus.Req = q;
    model_step(r, e, q);
    @(posedge Clk);
    #1;
    check_outputs();
    for (int i = 0; i < 4; i++) begin
      if (r || !e || !q[i] || bus.Gnt[i]) wait_cyc[i] = 0;
      else wait_cyc[i]++;
      if (starve_chk) chk("starve", (wait_cyc[i] <= STARVE_LIMIT), 1);
    end
  endtask

  function automatic int gnt_idx(logic [3:0] g);
    int k;
    k = -1;
    for (int i = 0; i < 4; i++) if (g[i]) k = i;
    return k;
  endfunction

  initial begin
    logic [3:0] q;
    int order [$];
    int held, gap, n1, nt;
    bit got;
    logic [3:0] prev_g;

    Rst = 1'b1; bus.En = 1'b0; bus.Req = 4'b0000;
    foreach (wait_cyc[i]) wait_cyc[i] = 0;

    // Reset values, then single request from requester 2.
    step(1, 0, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    chk("rst_cs", bus.Cs, 1'b1);
    chk("rst_addr", {bus.A1, bus.A0}, 2'b00);
    chk("rst_gnt", bus.Gnt, 4'b0000);
    step(0, 1, 4'b0100, 0);
    chk("t1_cs", bus.Cs, 1'b0);
    chk("t1_a1", bus.A1, 1'b1);
    chk("t1_a0", bus.A0, 1'b0);
    chk("t1_gnt", bus.Gnt, 4'b0100);
    chk("t1_busy", bus.Busy, 1'b1);
    step(0, 1, 4'b0000, 0);
    step(0, 1, 4'b0000, 0);

    // All request; each owner drops after two grant cycles.
    step(1, 0, 4'b0000, 0);
    q = 4'b1111; held = 0; gap = 0; prev_g = 4'b0000;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      step(0, 1, q, 0);
      if (bus.Gnt != 4'b0000) begin
        if (prev_g == 4'b0000) begin
          order.push_back(gnt_idx(bus.Gnt));
          if (order.size() > 1) chk("t2_gap", gap, 1);
          gap = 0; held = 0;
        end
        held++;
        if (held == 2) q[gnt_idx(bus.Gnt)] = 1'b0;
      end else begin
        if (order.size() > 0) gap++;
        q = 4'b1111;
      end
      prev_g = bus.Gnt;
    end
    chk("t2_count", order.size(), 5);
    for (int k = 0; k < order.size(); k++) chk("t2_order", order[k], k % 4);

    // Requester 1 holds past the limit; requester 2 waiting gets the bus next.
    step(1, 0, 4'b0000, 0);
    n1 = 0; nt = 0; got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      step(0, 1, 4'b0110, 0);
      if (bus.Gnt[1]) n1++;
      if (bus.TimeoutErr) nt++;
      if (bus.Gnt == 4'b0100) got = 1'b1;
    end
    chk("t3_hold", n1, MAX_HOLD);
    chk("t3_terr", nt, 1);
    chk("t3_next", got, 1'b1);

    // Reset while requester 3 owns the bus.
    step(1, 0, 4'b0000, 0);
    for (int c = 0; c < 3; c++) step(0, 1, 4'b1000, 0);
    chk("t4_pre", bus.Gnt, 4'b1000);
    step(1, 1, 4'b1000, 0);
    chk("t4_cs", bus.Cs, 1'b1);
    chk("t4_gnt", bus.Gnt, 4'b0000);
    step(0, 1, 4'b1001, 0);
    chk("t4_win", bus.Gnt, 4'b0001);

    // Enable gating in IDLE.
    step(1, 0, 4'b0000, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 4'b0010, 0);
      chk("t5_idle_cs", bus.Cs, 1'b1);
    end
    step(0, 1, 4'b0010, 0);
    chk("t5_gnt", bus.Gnt, 4'b0010);

    // Long random run.
    step(1, 0, 4'b0000, 0);
    foreach (wait_cyc[i]) wait_cyc[i] = 0;
    q = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 9) == 0) q[i] = ~q[i];
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 15) != 0), q, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
